// File: rtl/add_tree_seq.sv
// Sequencer that streams N chunk addresses into a pipelined adder tree and accumulates the returned sums.
// Latency: done N+TREE_LAT+2 cycles after start (1 cycle when N=0); start is ignored while busy.
module add_tree_seq #(
    parameter int WL       = 16,
    parameter int TREE_LAT = 4,
    parameter int CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] num_chunks,
    input  logic [WL-1:0] tree_sum,
    output logic          rd_en,
    output logic [CW-1:0] rd_addr,
    output logic          busy,
    output logic [WL-1:0] result,
    output logic          done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     n_q;
    logic [CW-1:0]     addr_q;
    logic [CW-1:0]     rem_q;
    logic [TREE_LAT:0] vld_sr;
    logic [WL-1:0]     acc;
    logic              tail;

    // Tail of the valid pipe lines up with tree_sum of an issued chunk
    // (one cycle of buffer read plus TREE_LAT cycles of tree).
    assign tail    = vld_sr[TREE_LAT];
    assign rd_en   = (state == S_ISSUE);
    assign rd_addr = addr_q;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign result  = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            n_q    <= '0;
            addr_q <= '0;
            rem_q  <= '0;
            vld_sr <= '0;
            acc    <= '0;
        end else begin
            vld_sr <= (vld_sr << 1) | (TREE_LAT+1)'(rd_en);

            if (tail) begin
                acc   <= acc + tree_sum;
                rem_q <= rem_q - CW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc <= '0;
                        if (num_chunks != '0) begin
                            n_q    <= num_chunks;
                            rem_q  <= num_chunks;
                            addr_q <= '0;
                            state  <= S_ISSUE;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (addr_q == n_q - CW'(1)) begin
                        state <= S_DRAIN;
                    end else begin
                        addr_q <= addr_q + CW'(1);
                    end
                end
                S_DRAIN: begin
                    // Leave on the edge that performs the final accumulation.
                    if (tail && rem_q == CW'(1)) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_tree_seq.sv
// Directed bench for add_tree_seq: models operand buffer plus adder-tree delay, scoreboards results.
module tb_add_tree_seq;

    localparam int WL       = 16;
    localparam int TREE_LAT = 4;
    localparam int CW       = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_chunks;
    logic [WL-1:0] tree_sum;
    logic          rd_en;
    logic [CW-1:0] rd_addr;
    logic          busy;
    logic [WL-1:0] result;
    logic          done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int done_seen = 0;
    int done_exp  = 0;

    logic [WL-1:0] mem [256];
    logic [WL-1:0] sb_q [$];

    // Environment: buffer read (1 cycle) followed by TREE_LAT-cycle tree; noise otherwise.
    logic [TREE_LAT:0] env_v = '0;
    logic [CW-1:0]     env_a [TREE_LAT+1];
    logic [WL-1:0]     noise = 16'h1234;

    add_tree_seq #(.WL(WL), .TREE_LAT(TREE_LAT), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_chunks (num_chunks),
        .tree_sum   (tree_sum),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .busy       (busy),
        .result     (result),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        env_v    <= {env_v[TREE_LAT-1:0], rd_en};
        env_a[0] <= rd_addr;
        for (int i = 1; i <= TREE_LAT; i++) env_a[i] <= env_a[i-1];
        noise    <= WL'($urandom_range(1, 65535));
    end

    assign tree_sum = env_v[TREE_LAT] ? mem[env_a[TREE_LAT]] : noise;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    // Start a reduction of n chunks in the current cycle and check every cycle up to done.
    task automatic reduce(input int n, input bit repulse);
        logic [WL-1:0] s;
        logic [WL-1:0] exp_res;
        int dk;
        s = '0;
        for (int i = 0; i < n; i++) s = s + mem[i];
        sb_q.push_back(s);
        done_exp++;
        dk = (n == 0) ? 1 : n + TREE_LAT + 2;
        next_cycle();
        start = 1'b1;
        num_chunks = CW'(n);
        @(negedge clk);
        for (int k = 1; k <= dk; k++) begin
            next_cycle();
            start = repulse && (k == 2 || k == 5);
            num_chunks = CW'($urandom_range(0, 255));
            @(negedge clk);
            check("rd_en", 32'(rd_en), 32'(k <= n));
            if (k <= n) check("rd_addr", 32'(rd_addr), 32'(k - 1));
            check("busy", 32'(busy), 32'd1);
            check("done", 32'(done), 32'(k == dk));
            if (k == dk) begin
                if (sb_q.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    exp_res = sb_q.pop_front();
                    check("result", 32'(result), 32'(exp_res));
                end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_chunks = '0;
        for (int i = 0; i < 256; i++) mem[i] = WL'($urandom_range(0, 65535));
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Basic N=3 run
        mem[0] = 16'd10; mem[1] = 16'd20; mem[2] = 16'd30;
        reduce(3, 1'b0);
        // Back-to-back runs with independent results
        mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd4;
        reduce(4, 1'b0);
        mem[0] = 16'd100; mem[1] = 16'd200;
        reduce(2, 1'b0);
        // Empty reduction
        reduce(0, 1'b0);
        // Wraparound
        mem[0] = 16'h7FFF; mem[1] = 16'h0002;
        reduce(2, 1'b0);
        // Start re-pulsed while busy
        mem[0] = 16'd10; mem[1] = 16'd20; mem[2] = 16'd30;
        reduce(3, 1'b1);
        next_cycle();
        @(negedge clk);
        check("held_result", 32'(result), 32'd60);
        check("held_busy", 32'(busy), 32'd0);

        // Reset in cycle 4 of an N=3 run aborts without done
        next_cycle();
        start = 1'b1;
        num_chunks = 8'd3;
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            start = 1'b0;
            rst = (k == 4);
        end
        for (int k = 5; k <= 11; k++) begin
            next_cycle();
            rst = 1'b0;
            @(negedge clk);
            check("abort_done", 32'(done), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_result", 32'(result), 32'd0);
            check("abort_rd_en", 32'(rd_en), 32'd0);
        end
        mem[0] = 16'd7;
        reduce(1, 1'b0);

        // Start coincident with reset is ignored
        next_cycle();
        rst = 1'b1;
        start = 1'b1;
        num_chunks = 8'd5;
        next_cycle();
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", 32'(busy), 32'd0);
        next_cycle();
        @(negedge clk);
        check("rst_start_rd_en", 32'(rd_en), 32'd0);

        // Maximum chunk count, no address wrap
        for (int i = 0; i < 256; i++) mem[i] = WL'($urandom_range(0, 65535));
        reduce(255, 1'b0);
        next_cycle();
        @(negedge clk);
        check("max_addr_hold", 32'(rd_addr), 32'd254);

        check("done_count", 32'(done_seen), 32'(done_exp));
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_tree_seq.md
ADD_TREE_SEQ -- requirements
Module: add_tree_seq

Interface
REQ-001 Parameter WL, default 16, data word width of the adder-tree output and accumulator.
REQ-002 Parameter TREE_LAT, default 4, clock cycles from adder-tree input to adder-tree output (sum).
REQ-003 Parameter CW, default 8, width of chunk count and read address.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a reduction; honoured only in IDLE.
REQ-007 num_chunks  input  CW  number of 16-word chunks to reduce, sampled with start.
REQ-008 tree_sum  input  WL  adder-tree output sum (two's complement).
REQ-009 rd_en  output  1  read strobe to the 16-lane operand buffer feeding the adder tree (buffer read latency 1 cycle).
REQ-010 rd_addr  output  CW  chunk address for the operand buffer.
REQ-011 busy  output  1  high from the cycle after start is accepted until done is asserted, inclusive of the done cycle.
REQ-012 result  output  WL  accumulated total; held until the next accepted start.
REQ-013 done  output  1  one-cycle pulse, result valid.

Function
REQ-014 States SHALL be IDLE, ISSUE, DRAIN, DONE; reset state IDLE.
REQ-015 IDLE: start=1 with num_chunks>0 -> latch N=num_chunks, clear accumulator, go ISSUE; start=1 with num_chunks=0 -> clear accumulator, go DONE; else stay.
REQ-016 ISSUE: rd_en=1, rd_addr=0,1,...,N-1 on consecutive cycles, one chunk per cycle, no gaps; after address N-1 go DRAIN.
REQ-017 A valid shift register of depth TREE_LAT+1 SHALL track each rd_en; its tail marks the cycle tree_sum belongs to an issued chunk.
REQ-018 When the tail is 1, accumulator <= accumulator + tree_sum, modulo 2^WL (wrap, no saturation, no overflow flag).
REQ-019 DRAIN: rd_en=0; go DONE on the edge that performs the N-th accumulation (in-flight count reaches zero).
REQ-020 DONE: done=1, busy=1, result=accumulator for exactly one cycle; then IDLE with result held.
REQ-021 Timing: start sampled in cycle 0 -> rd_en cycles 1..N, accumulations at end of cycles TREE_LAT+2..N+TREE_LAT+1, done in cycle N+TREE_LAT+2; num_chunks=0 -> done in cycle 1.
REQ-022 start while busy SHALL be ignored with no effect on the current reduction or latched N.
REQ-023 tree_sum SHALL be ignored whenever the valid tail is 0.
REQ-024 N=2^CW-1 SHALL complete without rd_addr wrap; rd_addr holds its last value when rd_en=0.
REQ-025 num_chunks changes after acceptance SHALL have no effect.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, rd_en=0, rd_addr=0, busy=0, done=0, result=0, accumulator=0, valid shift register all zero.
REQ-027 rst mid-reduction SHALL abort with no done pulse; in-flight tree_sum values arriving after reset SHALL not be accumulated.
REQ-028 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-029 TREE_LAT=4, start with N=3, tree_sum driven 10,20,30 in cycles 6,7,8 -> rd_en cycles 1..3 addr 0,1,2; done in cycle 9 with result=60; busy cycles 1..9.
REQ-030 start with N=0 -> no rd_en, done in cycle 1, result=0.
REQ-031 N=2, tree_sum 0x7FFF then 0x0002 -> result=0x8001 (wrap).
REQ-032 start re-pulsed in cycles 2 and 5 of an N=3 run -> single done in cycle 9, result unchanged versus REQ-029.
REQ-033 rst in cycle 4 of an N=3 run, tree_sum nonzero in cycles 5..10 -> no done, result=0, busy=0 from cycle 5; next start with N=1, tree_sum=7 -> result=7.
REQ-034 Back-to-back: start in the cycle after done -> accepted; second result independent of first (accumulator cleared).
